// File: rtl/qtr_pkg.sv
// Shared definitions for the QTR reflectance-sensor reader and its emulator.
package qtr_pkg;

  // Width of a sensor reading / decay value in 10 us units.
  localparam int VALUE_W = 8;

  // Pin-emulation states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHARGING = 2'd1,
    DECAY    = 2'd2
  } qtr_state_e;

  // Clock cycles per 10 us tick for a given clock rate in Hz.
  function automatic int ten_us_count(input int clk_frequency);
    return clk_frequency / 100_000;
  endfunction

endpackage

// File: rtl/qtr_tick.sv
// 10 us prescaler: counts 0..TEN_US_COUNT-1 and emits a one-cycle tick on
// the last count. A synchronous clear holds it at zero and masks the tick.
module qtr_tick #(
  parameter int TEN_US_COUNT = 600
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TEN_US_COUNT > 1) ? $clog2(TEN_US_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TEN_US_COUNT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running modulo counter, restarted from zero by clr.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/qtr_emu.sv
// Far-end emulator for a QTR sensor pin. Watches the reader's pin drive and
// returns the level the reader would sense: a qualified charge followed by a
// release holds the line high for the latched decay time, then lets it fall.
module qtr_emu
  import qtr_pkg::*;
#(
  parameter int CLK_FREQUENCY     = 60_000_000,
  parameter int TEN_US_COUNT      = ten_us_count(CLK_FREQUENCY),
  parameter int MIN_CHARGE_CYCLES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [VALUE_W-1:0] decay,
  input  logic               host_out_en,
  input  logic               host_out_sig,
  output logic               sense,
  output logic               busy,
  output logic               done,
  output logic [15:0]        reads
);

  localparam int CHG_W = (MIN_CHARGE_CYCLES > 0) ? $clog2(MIN_CHARGE_CYCLES + 1) : 1;
  localparam logic [CHG_W-1:0] CHG_MIN = CHG_W'(MIN_CHARGE_CYCLES);

  logic               hen_meta, hen;
  logic               hsig_meta, hsig;
  qtr_state_e         state, state_nxt;
  logic [CHG_W-1:0]   chg_cnt, chg_cnt_nxt;
  logic [VALUE_W-1:0] dec_lat;
  logic [VALUE_W-1:0] tick_cnt;
  logic               tick;
  logic               tick_clr;
  logic               decay_end;
  logic               latch_decay;
  logic               sense_nxt;
  logic               done_nxt;

  // Two-flop synchronizers for the asynchronous host pin drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      hen_meta  <= 1'b0;
      hen       <= 1'b0;
      hsig_meta <= 1'b0;
      hsig      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the previous
      // stage's old value; blocking ones would collapse the chain to one flop.
      hen_meta  <= host_out_en;
      hen       <= hen_meta;
      hsig_meta <= host_out_sig;
      hsig      <= hsig_meta;
    end
  end

  // Prescaler runs only in DECAY, so the first DECAY cycle always sees zero.
  assign tick_clr = (state != DECAY);

  qtr_tick #(
    .TEN_US_COUNT(TEN_US_COUNT)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Decay finishes on the cycle whose tick brings the count up to the latched
  // value, so the registered fall lands exactly decay*TEN_US_COUNT cycles in.
  assign decay_end = (dec_lat == '0) ||
                     (tick && (({1'b0, tick_cnt} + 1'b1) == {1'b0, dec_lat}));

  // Next-state, charge counter and output decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    chg_cnt_nxt = chg_cnt;
    latch_decay = 1'b0;
    done_nxt    = 1'b0;

    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (hen && hsig) begin
            state_nxt   = CHARGING;
            chg_cnt_nxt = '0;
          end
        end
        CHARGING: begin
          if (hen && hsig) begin
            if (chg_cnt != CHG_MIN) chg_cnt_nxt = chg_cnt + 1'b1;
          end else if (hen) begin
            state_nxt = IDLE;
          end else if (chg_cnt >= CHG_MIN) begin
            state_nxt   = DECAY;
            latch_decay = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        DECAY: begin
          if (hen && hsig) begin
            state_nxt   = CHARGING;
            chg_cnt_nxt = '0;
          end else if (hen) begin
            state_nxt = IDLE;
          end else if (decay_end) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Host drive always wins; otherwise the line is high only while decaying.
    sense_nxt = hen ? hsig : (state_nxt == DECAY);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      chg_cnt  <= '0;
      dec_lat  <= '0;
      tick_cnt <= '0;
      sense    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      reads    <= '0;
    end else begin
      state   <= state_nxt;
      chg_cnt <= chg_cnt_nxt;
      if (latch_decay) dec_lat <= decay;
      if (state != DECAY) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      sense <= sense_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= done_nxt;
      if (done_nxt) reads <= reads + 1'b1;
    end
  end

endmodule

// File: doc/qtr_emu.md
# qtr_emu

Emulator for the far end of the Pololu QTR reflectance-sensor pin: it observes the host reader's pin drive and produces the pin level the reader senses. After a qualified charge pulse and host release, the line stays high for a programmed decay time in 10 µs units, then goes low. It is used in simulation and hardware-in-the-loop builds, where it replaces the physical sensor behind the QTR reader's pin signals.

## Interface
Parameters:
- CLK_FREQUENCY, 60_000_000, clk rate in Hz
- TEN_US_COUNT, CLK_FREQUENCY/100_000, clk cycles per 10 µs tick
- MIN_CHARGE_CYCLES, 60, minimum host high-drive length (synchronized cycles) that charges the emulated capacitor

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  emulation enable; 0 forces IDLE
- decay  in  8  decay time in 10 µs units; latched on entry to DECAY
- host_out_en  in  1  reader pin output-enable (asynchronous)
- host_out_sig  in  1  reader pin output value (asynchronous)
- sense  out  1  emulated pin level, fed to the reader's pin input
- busy  out  1  high in CHARGING or DECAY
- done  out  1  one-cycle pulse when a decay completes normally
- reads  out  16  count of completed decays; wraps 0xFFFF→0

## Operation
- Both host inputs pass through 2-flop synchronizers (reset to 0). All logic below uses the synchronized values, hen and hsig.
- The host drives the pin when hen=1. In every state, when hen=1, sense follows hsig.
- States:
  - IDLE: sense=0 when hen=0.
    - hen&hsig & en → CHARGING, with the charge counter cleared.
  - CHARGING: the charge counter increments each cycle while hen&hsig, saturating at MIN_CHARGE_CYCLES.
    - hen=1 & hsig=0: host discharges the pin → IDLE.
    - hen=0 with counter ≥ MIN_CHARGE_CYCLES → DECAY. Latch decay, clear the prescaler and tick count, sense=1.
    - hen=0 with counter < MIN_CHARGE_CYCLES → IDLE, sense=0. No done pulse, no reads increment.
  - DECAY: sense=1 when hen=0.
    - The prescaler counts 0..TEN_US_COUNT-1; each wrap increments the tick count.
    - Tick count == latched decay → sense=0, done=1 for one cycle, reads+1, → IDLE.
    - Latched decay=0 → exits on the first DECAY cycle; sense high for 1 cycle.
    - hen&hsig during DECAY: re-charge → CHARGING, with the counter cleared. No done pulse.
    - hen=1 & hsig=0 → IDLE. No done pulse.
- en=0 in any state → IDLE next cycle, with no done pulse. In IDLE, sense still follows host drive.
- Changes to decay during DECAY have no effect; only the latched value is used.
- Reset mid-operation returns all state to reset values on the next edge.

## Timing
- Reset values: sense=0, busy=0, done=0, reads=0, state IDLE, synchronizers 0, counters 0.
- sense is registered. A host drive change appears at sense 3 cycles later (2 synchronizer + 1 output register).
- Release to fall: the synchronized release edge is followed by sense=1 for exactly decay×TEN_US_COUNT cycles (1 cycle when decay=0). sense then falls in the same cycle that done pulses.
- busy is registered with the state and is high in CHARGING and DECAY.
- Maximum decay is 255×TEN_US_COUNT cycles, which is 2.55 ms at default parameters.

## Structure
- Shared package/include qtr_pkg holds:
  - the state encoding localparams (IDLE, CHARGING, DECAY);
  - the TEN_US_COUNT derivation;
  - the 8-bit value width, shared with the reader.
- Sub-module qtr_tick: a 10 µs prescaler with synchronous clear and a one-cycle tick output. It is shared with the reader.
- Synchronizers are inline.

## Test plan
Bench parameters: CLK_FREQUENCY=1_000_000, so TEN_US_COUNT=10; MIN_CHARGE_CYCLES=4.
- Decay=20, host drives high for 10 cycles, then releases → sense high for exactly 200 cycles after the synchronized release, then low. done pulses once, reads=1.
- Decay=0, valid charge → sense high 1 cycle. done pulses, reads increments.
- Host charge of 2 cycles, then release → sense=0 three cycles after release. No done pulse, reads unchanged.
- Decay=50; host re-drives high 100 cycles into DECAY, holds 10 cycles, releases → a fresh 500-cycle high period after the release. Exactly one done pulse, at the end.
- en deasserted 30 cycles into DECAY → IDLE next cycle, sense=0. No done pulse. Reset asserted mid-DECAY → all outputs 0 on the next cycle.
- reads preloaded via 65535 completed decays (force-accelerated) → the next done wraps reads to 0. Closed loop with the QTR reader (decay=37) → the reader's valid value lies within 36..38.
